pipe_ctrl_unit: RTL and testbench

Sequential consumer of the 12-bit control bundle from the instruction decoder in the 5-stage MIPS pipeline. It carries the bundle and destination register through ID/EX, EX/MEM and MEM/WB. It detects load-use hazards and generates stall, drives EX operand forwarding selects, resolves branch and jump redirects, and inserts bubbles.

---
 rtl/pipe_ctrl_unit_if.sv | 36 +++
 rtl/pipe_ctrl_unit.sv | 126 ++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_unit_if.sv
// rtl/pipe_ctrl_unit_if.sv - ID-stage inputs and pipeline-control outputs of pipe_ctrl_unit
interface pipe_ctrl_unit_if #(
  parameter int SIG_W = 12,
  parameter int REG_W = 5
);
  logic             id_valid;
  logic [SIG_W-1:0] id_sig;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic             ex_zero;
  logic [SIG_W-1:0] ex_sig;
  logic [SIG_W-1:0] mem_sig;
  logic [SIG_W-1:0] wb_sig;
  logic [REG_W-1:0] ex_rs;
  logic [REG_W-1:0] ex_rt;
  logic [REG_W-1:0] mem_dst;
  logic [REG_W-1:0] wb_dst;
  logic             stall;
  logic             flush_ifid;
  logic [1:0]       pc_sel;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  modport master (
    output id_valid, id_sig, id_rs, id_rt, id_rd, ex_zero,
    input  ex_sig, mem_sig, wb_sig, ex_rs, ex_rt, mem_dst, wb_dst,
    input  stall, flush_ifid, pc_sel, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_sig, id_rs, id_rt, id_rd, ex_zero,
    output ex_sig, mem_sig, wb_sig, ex_rs, ex_rt, mem_dst, wb_dst,
    output stall, flush_ifid, pc_sel, fwd_a, fwd_b
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - MIPS pipeline control: stage bundles, hazard stall, forwarding, redirects
module pipe_ctrl_unit #(
  parameter int SIG_W = 12,
  parameter int REG_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_ctrl_unit_if.slave bus
);

  localparam int B_INVBR   = 10;
  localparam int B_REGDST  = 8;
  localparam int B_MEM2REG = 6;
  localparam int B_WREG    = 5;
  localparam int B_MEMWR   = 4;
  localparam int B_BRANCH  = 3;
  localparam int B_JUMP    = 0;

  logic [SIG_W-1:0] ex_sig_q, ex_sig_d;
  logic [SIG_W-1:0] mem_sig_q, mem_sig_d;
  logic [SIG_W-1:0] wb_sig_q, wb_sig_d;
  logic [REG_W-1:0] ex_rs_q, ex_rs_d;
  logic [REG_W-1:0] ex_rt_q, ex_rt_d;
  logic [REG_W-1:0] ex_dst_q, ex_dst_d;
  logic [REG_W-1:0] mem_dst_q, mem_dst_d;
  logic [REG_W-1:0] wb_dst_q, wb_dst_d;

  logic             uses_rs, uses_rt, load_use, br_taken, id_jump;
  logic [REG_W-1:0] id_dst;
  logic             stall, flush_ifid;
  logic [1:0]       pc_sel, fwd_a, fwd_b;

  always_comb begin
    uses_rs  = bus.id_valid & ~bus.id_sig[B_JUMP];
    uses_rt  = bus.id_valid & (bus.id_sig[B_REGDST] | bus.id_sig[B_MEMWR] | bus.id_sig[B_BRANCH]);
    id_dst   = bus.id_sig[B_REGDST] ? bus.id_rd : bus.id_rt;
    id_jump  = bus.id_valid & bus.id_sig[B_JUMP];
    load_use = ex_sig_q[B_MEM2REG] & (ex_dst_q != '0) &
               ((uses_rs & (ex_dst_q == bus.id_rs)) | (uses_rt & (ex_dst_q == bus.id_rt)));
    br_taken = ex_sig_q[B_BRANCH] & (bus.ex_zero ^ ex_sig_q[B_INVBR]);

    stall      = 1'b0;
    flush_ifid = 1'b0;
    pc_sel     = 2'b00;
    ex_sig_d   = '0;
    ex_rs_d    = '0;
    ex_rt_d    = '0;
    ex_dst_d   = '0;

    // A taken branch squashes whatever sits in ID, so it outranks the stall and the jump
    if (br_taken) begin
      pc_sel     = 2'b01;
      flush_ifid = 1'b1;
    end else if (load_use) begin
      stall = 1'b1;
    end else begin
      if (id_jump) begin
        pc_sel     = 2'b10;
        flush_ifid = 1'b1;
      end
      if (bus.id_valid) begin
        ex_sig_d = bus.id_sig;
        ex_rs_d  = bus.id_rs;
        ex_rt_d  = bus.id_rt;
        ex_dst_d = id_dst;
      end
    end

    mem_sig_d = ex_sig_q;
    mem_dst_d = ex_dst_q;
    wb_sig_d  = mem_sig_q;
    wb_dst_d  = mem_dst_q;
  end

  // EX/MEM result is newer than MEM/WB, so it is checked first; r0 never forwards
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_sig_q[B_WREG] && (mem_dst_q != '0) && (mem_dst_q == ex_rs_q)) begin
      fwd_a = 2'b01;
    end else if (wb_sig_q[B_WREG] && (wb_dst_q != '0) && (wb_dst_q == ex_rs_q)) begin
      fwd_a = 2'b10;
    end
    if (mem_sig_q[B_WREG] && (mem_dst_q != '0) && (mem_dst_q == ex_rt_q)) begin
      fwd_b = 2'b01;
    end else if (wb_sig_q[B_WREG] && (wb_dst_q != '0) && (wb_dst_q == ex_rt_q)) begin
      fwd_b = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_sig_q  <= '0;
      mem_sig_q <= '0;
      wb_sig_q  <= '0;
      ex_rs_q   <= '0;
      ex_rt_q   <= '0;
      ex_dst_q  <= '0;
      mem_dst_q <= '0;
      wb_dst_q  <= '0;
    end else begin
      ex_sig_q  <= ex_sig_d;
      mem_sig_q <= mem_sig_d;
      wb_sig_q  <= wb_sig_d;
      ex_rs_q   <= ex_rs_d;
      ex_rt_q   <= ex_rt_d;
      ex_dst_q  <= ex_dst_d;
      mem_dst_q <= mem_dst_d;
      wb_dst_q  <= wb_dst_d;
    end
  end

  assign bus.ex_sig     = ex_sig_q;
  assign bus.mem_sig    = mem_sig_q;
  assign bus.wb_sig     = wb_sig_q;
  assign bus.ex_rs      = ex_rs_q;
  assign bus.ex_rt      = ex_rt_q;
  assign bus.mem_dst    = mem_dst_q;
  assign bus.wb_dst     = wb_dst_q;
  assign bus.stall      = stall;
  assign bus.flush_ifid = flush_ifid;
  assign bus.pc_sel     = pc_sel;
  assign bus.fwd_a      = fwd_a;
  assign bus.fwd_b      = fwd_b;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - directed self-checking bench for pipe_ctrl_unit
module tb_pipe_ctrl_unit;

  localparam logic [11:0] ADDI = 12'h0A0;
  localparam logic [11:0] LW   = 12'h0E0;
  localparam logic [11:0] RT   = 12'h124;
  localparam logic [11:0] BEQ  = 12'h00A;
  localparam logic [11:0] BNE  = 12'h40A;
  localparam logic [11:0] JMP  = 12'h001;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pipe_ctrl_unit_if bus ();

  pipe_ctrl_unit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [11:0] s, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd);
    bus.id_valid = v;
    bus.id_sig   = s;
    bus.id_rs    = rs;
    bus.id_rt    = rt;
    bus.id_rd    = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ex_sig"},  bus.ex_sig, 12'h0);
    chk({tag, ".mem_sig"}, bus.mem_sig, 12'h0);
    chk({tag, ".wb_sig"},  bus.wb_sig, 12'h0);
    chk({tag, ".ex_rs"},   {7'd0, bus.ex_rs}, 12'h0);
    chk({tag, ".ex_rt"},   {7'd0, bus.ex_rt}, 12'h0);
    chk({tag, ".mem_dst"}, {7'd0, bus.mem_dst}, 12'h0);
    chk({tag, ".wb_dst"},  {7'd0, bus.wb_dst}, 12'h0);
    chk({tag, ".stall"},   {11'd0, bus.stall}, 12'h0);
    chk({tag, ".flush"},   {11'd0, bus.flush_ifid}, 12'h0);
    chk({tag, ".pc_sel"},  {10'd0, bus.pc_sel}, 12'h0);
    chk({tag, ".fwd_a"},   {10'd0, bus.fwd_a}, 12'h0);
    chk({tag, ".fwd_b"},   {10'd0, bus.fwd_b}, 12'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.ex_zero = 1'b0;
    drive(1'b0, 12'h0, 5'd0, 5'd0, 5'd0);

    // reset
    tick();
    chk_all_zero("reset");
    #2 rst_n = 1'b1;

    // propagation ADDI rt=8
    drive(1'b1, ADDI, 5'd1, 5'd8, 5'd0);
    #1;
    chk("prop.stall0", {11'd0, bus.stall}, 12'h0);
    chk("prop.pcsel0", {10'd0, bus.pc_sel}, 12'h0);
    tick();
    chk("prop.ex_sig", bus.ex_sig, ADDI);
    chk("prop.ex_rt", {7'd0, bus.ex_rt}, 12'd8);
    chk("prop.ex_rs", {7'd0, bus.ex_rs}, 12'd1);
    drive(1'b0, 12'h0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("prop.mem_sig", bus.mem_sig, ADDI);
    chk("prop.mem_dst", {7'd0, bus.mem_dst}, 12'd8);
    chk("prop.ex_bubble", bus.ex_sig, 12'h0);
    tick();
    chk("prop.wb_sig", bus.wb_sig, ADDI);
    chk("prop.wb_dst", {7'd0, bus.wb_dst}, 12'd8);
    chk("prop.pcsel_end", {10'd0, bus.pc_sel}, 12'h0);
    tick();

    // load-use: LW rt=9 then R-type rs=9
    drive(1'b1, LW, 5'd0, 5'd9, 5'd0);
    tick();
    chk("lu.ex_lw", bus.ex_sig, LW);
    drive(1'b1, ADDI, 5'd0, 5'd9, 5'd0);
    #1;
    chk("lu.addi_rt_no_stall", {11'd0, bus.stall}, 12'h0);
    drive(1'b1, JMP, 5'd9, 5'd0, 5'd0);
    #1;
    chk("lu.jump_no_stall", {11'd0, bus.stall}, 12'h0);
    chk("lu.jump_pcsel", {10'd0, bus.pc_sel}, 12'h2);
    drive(1'b1, RT, 5'd9, 5'd3, 5'd10);
    #1;
    chk("lu.stall", {11'd0, bus.stall}, 12'h1);
    chk("lu.pcsel", {10'd0, bus.pc_sel}, 12'h0);
    chk("lu.flush", {11'd0, bus.flush_ifid}, 12'h0);
    tick();
    chk("lu.ex_bubble", bus.ex_sig, 12'h0);
    chk("lu.mem_lw", bus.mem_sig, LW);
    chk("lu.stall_once", {11'd0, bus.stall}, 12'h0);
    tick();
    chk("lu.ex_rtype", bus.ex_sig, RT);
    chk("lu.ex_rs", {7'd0, bus.ex_rs}, 12'd9);
    chk("lu.wb_dst", {7'd0, bus.wb_dst}, 12'd9);
    chk("lu.fwd_a", {10'd0, bus.fwd_a}, 12'h2);
    chk("lu.fwd_b", {10'd0, bus.fwd_b}, 12'h0);
    drive(1'b0, 12'h0, 5'd0, 5'd0, 5'd0);
    tick(); tick(); tick();

    // forwarding priority, dst=5
    drive(1'b1, ADDI, 5'd0, 5'd5, 5'd0);
    tick();
    tick();
    drive(1'b1, RT, 5'd5, 5'd5, 5'd6);
    tick();
    chk("fp.fwd_a", {10'd0, bus.fwd_a}, 12'h1);
    chk("fp.fwd_b", {10'd0, bus.fwd_b}, 12'h1);
    drive(1'b0, 12'h0, 5'd0, 5'd0, 5'd0);
    tick(); tick(); tick();

    // forwarding with dst=0
    drive(1'b1, ADDI, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    drive(1'b1, RT, 5'd0, 5'd0, 5'd6);
    tick();
    chk("f0.ex_sig", bus.ex_sig, RT);
    chk("f0.fwd_a", {10'd0, bus.fwd_a}, 12'h0);
    chk("f0.fwd_b", {10'd0, bus.fwd_b}, 12'h0);
    drive(1'b0, 12'h0, 5'd0, 5'd0, 5'd0);
    tick(); tick(); tick();

    // BEQ taken
    drive(1'b1, BEQ, 5'd1, 5'd2, 5'd0);
    tick();
    drive(1'b1, ADDI, 5'd0, 5'd7, 5'd0);
    bus.ex_zero = 1'b1;
    #1;
    chk("beq.pcsel", {10'd0, bus.pc_sel}, 12'h1);
    chk("beq.flush", {11'd0, bus.flush_ifid}, 12'h1);
    chk("beq.stall", {11'd0, bus.stall}, 12'h0);
    tick();
    chk("beq.ex_bubble", bus.ex_sig, 12'h0);
    chk("beq.mem", bus.mem_sig, BEQ);
    bus.ex_zero = 1'b0;

    // BNE
    drive(1'b1, BNE, 5'd1, 5'd2, 5'd0);
    tick();
    drive(1'b0, 12'h0, 5'd0, 5'd0, 5'd0);
    bus.ex_zero = 1'b1;
    #1;
    chk("bne.z1.pcsel", {10'd0, bus.pc_sel}, 12'h0);
    chk("bne.z1.flush", {11'd0, bus.flush_ifid}, 12'h0);
    bus.ex_zero = 1'b0;
    #1;
    chk("bne.z0.pcsel", {10'd0, bus.pc_sel}, 12'h1);
    chk("bne.z0.flush", {11'd0, bus.flush_ifid}, 12'h1);
    tick();

    // taken branch vs consumer in ID, then vs jump in ID
    drive(1'b1, BEQ, 5'd1, 5'd2, 5'd0);
    tick();
    drive(1'b1, RT, 5'd1, 5'd2, 5'd3);
    bus.ex_zero = 1'b1;
    #1;
    chk("sim.cons.stall", {11'd0, bus.stall}, 12'h0);
    chk("sim.cons.pcsel", {10'd0, bus.pc_sel}, 12'h1);
    drive(1'b1, JMP, 5'd0, 5'd0, 5'd0);
    #1;
    chk("sim.jmp.pcsel", {10'd0, bus.pc_sel}, 12'h1);
    chk("sim.jmp.flush", {11'd0, bus.flush_ifid}, 12'h1);
    tick();
    chk("sim.jmp.ex_bubble", bus.ex_sig, 12'h0);
    bus.ex_zero = 1'b0;
    #1;
    chk("jmp.pcsel", {10'd0, bus.pc_sel}, 12'h2);
    chk("jmp.flush", {11'd0, bus.flush_ifid}, 12'h1);
    tick();
    chk("jmp.ex_sig", bus.ex_sig, JMP);
    drive(1'b0, 12'h0, 5'd0, 5'd0, 5'd0);
    tick(); tick(); tick();

    // asynchronous reset with three in flight
    drive(1'b1, ADDI, 5'd0, 5'd5, 5'd0);
    tick();
    tick();
    drive(1'b1, RT, 5'd5, 5'd5, 5'd6);
    tick();
    drive(1'b0, 12'h0, 5'd0, 5'd0, 5'd0);
    chk("rst.pre_fwd_a", {10'd0, bus.fwd_a}, 12'h1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, ADDI, 5'd0, 5'd8, 5'd0);
    tick();
    chk("post.ex_sig", bus.ex_sig, ADDI);
    chk("post.fwd_a", {10'd0, bus.fwd_a}, 12'h0);
    chk("post.fwd_b", {10'd0, bus.fwd_b}, 12'h0);
    chk("post.mem_sig", bus.mem_sig, 12'h0);
    drive(1'b0, 12'h0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("post.mem_dst", {7'd0, bus.mem_dst}, 12'd8);
    tick();
    chk("post.wb_sig", bus.wb_sig, ADDI);
    chk("post.wb_dst", {7'd0, bus.wb_dst}, 12'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
